// File: rtl/fib_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter fed by the Fibonacci calculator's level done.
// Optional leading-zero blanking (4'hF) at completion when FIB_BCD_BLANK_EN is defined.
module fib_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_work;
    logic [WIDTH-1:0]   bin_shifted;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [BCD_W-1:0]   bcd_final;
    logic               accept;
    logic               last_shift;

    // Decimal digits needed to hold 2^w - 1.
    function automatic int min_digits(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        while (v != 64'd0) begin
            v = v / 64'd10;
            n++;
        end
        return (n == 0) ? 1 : n;
    endfunction

    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
        $error("fib_bcd_converter: DIGITS too small for WIDTH");
    end

    // Per-nibble add-3 correction, modulo 16, no carry between digits.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            nib = d[4*i +: 4];
            r[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        return r;
    endfunction

`ifdef FIB_BCD_BLANK_EN
    // Replace zeros above the most significant nonzero digit with the blank code.
    function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = d;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (d[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        {bcd_shifted, bin_shifted} = {add3(bcd_work), bin_sr} << 1;
    end

`ifdef FIB_BCD_BLANK_EN
    assign bcd_final = blank_lead(bcd_shifted);
`else
    assign bcd_final = bcd_shifted;
`endif

    assign accept     = (state == IDLE) && start;
    assign last_shift = (state == SHIFT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = SHIFT;
            SHIFT:   if (cnt == '0)   state_nxt = DONE;
            DONE:    if (!start)      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    // Control and result registers: cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            valid   <= 1'b0;
            bcd_out <= '0;
        end else begin
            if (accept) begin
                cnt   <= CNT_W'(WIDTH - 1);
                valid <= 1'b0;
            end else if (state == SHIFT) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
                if (last_shift) begin
                    valid   <= 1'b1;
                    bcd_out <= bcd_final;
                end
            end
        end
    end

    // Working shift registers: contents are don't-care outside SHIFT.
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_sr   <= bin_in;
            bcd_work <= '0;
        end else if (state == SHIFT) begin
            bin_sr   <= bin_shifted;
            bcd_work <= bcd_shifted;
        end
    end

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Self-checking bench for fib_bcd_converter: vector table, hand sequences, random vs decimal model.
// Follows FIB_BCD_BLANK_EN so expectations match the build under test.
module tb_fib_bcd_converter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  bin_in;
    logic              busy;
    logic              valid;
    logic [19:0]       bcd_out;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int bad_change = 0;

    fib_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .valid   (valid),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        bit          hold;
        logic [19:0] exp_plain;
        logic [19:0] exp_blank;
    } vec_t;

    // Decimal reference: digits by repeated division, optional leading blanking.
    function automatic logic [19:0] model(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef FIB_BCD_BLANK_EN
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (r[4*i +: 4] != 4'd0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Invariants watched every cycle.
    logic [19:0] prev_bcd = '0;
    logic        prev_valid = 1'b0;
    logic        prev_rst = 1'b1;
    always @(negedge clk) begin
        if (busy && valid) overlap++;
        if ((bcd_out != prev_bcd) && !(valid && !prev_valid) && !prev_rst) bad_change++;
        prev_bcd   = bcd_out;
        prev_valid = valid;
        prev_rst   = reset;
    end

    task automatic accept_val(input logic [15:0] v);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
    endtask

    // Counts samples after the acceptance edge until valid; also busy samples.
    task automatic wait_done(input bit drop, input int chg_at, input logic [15:0] chg_val,
                             output int n, output int bn, output bit v0);
        n  = 0;
        bn = 0;
        @(negedge clk);
        v0 = valid;
        if (drop) start = 1'b0;
        while (!valid && n < 40) begin
            if (busy) bn++;
            n++;
            if (n == chg_at) bin_in = chg_val;
            @(negedge clk);
        end
    endtask

    vec_t vecs[8];
    int   n, bn, held_bad;
    bit   v0;
    logic [15:0] rv;

    initial begin
        vecs[0] = '{16'd0,     1'b0, 20'h00000, 20'hFFFF0};
        vecs[1] = '{16'd6765,  1'b1, 20'h06765, 20'hF6765};
        vecs[2] = '{16'd65535, 1'b0, 20'h65535, 20'h65535};
        vecs[3] = '{16'd55,    1'b0, 20'h00055, 20'hFFF55};
        vecs[4] = '{16'd10000, 1'b0, 20'h10000, 20'h10000};
        vecs[5] = '{16'd1,     1'b0, 20'h00001, 20'hFFFF1};
        vecs[6] = '{16'd9999,  1'b0, 20'h09999, 20'hF9999};
        vecs[7] = '{16'd40960, 1'b0, 20'h40960, 20'h40960};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            accept_val(vecs[i].bin);
            wait_done(!vecs[i].hold, -1, '0, n, bn, v0);
            check($sformatf("latency_%0d", i), 32'(n), 32'(WIDTH));
            check($sformatf("busy_cycles_%0d", i), 32'(bn), 32'(WIDTH));
`ifdef FIB_BCD_BLANK_EN
            check($sformatf("bcd_%0d", i), 32'(bcd_out), 32'(vecs[i].exp_blank));
`else
            check($sformatf("bcd_%0d", i), 32'(bcd_out), 32'(vecs[i].exp_plain));
`endif
            if (vecs[i].hold) begin
                held_bad = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (busy || !valid || bcd_out != model(vecs[i].bin)) held_bad++;
                end
                check("held_start_no_retrigger", 32'(held_bad), 32'd0);
                start = 1'b0;
            end
        end

        // Input change mid-SHIFT must not disturb the captured value.
        accept_val(16'd1597);
        wait_done(1'b1, 5, 16'd4181, n, bn, v0);
        check("capture_latency", 32'(n), 32'(WIDTH));
        check("capture_bcd", 32'(bcd_out), 32'(model(1597)));
        accept_val(16'd4181);
        wait_done(1'b1, -1, '0, n, bn, v0);
        check("valid_drop_after_accept", 32'(v0), 32'd0);
        check("reconvert_bcd", 32'(bcd_out), 32'(model(4181)));

        // Reset during SHIFT discards the partial result.
        accept_val(16'd1234);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midshift_reset_busy", 32'(busy), 32'd0);
        check("midshift_reset_valid", 32'(valid), 32'd0);
        check("midshift_reset_bcd", 32'(bcd_out), 32'd0);
        accept_val(16'd89);
        wait_done(1'b1, -1, '0, n, bn, v0);
        check("post_reset_latency", 32'(n), 32'(WIDTH));
        check("post_reset_bcd", 32'(bcd_out), 32'(model(89)));

        // Randomized values with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            rv = 16'($urandom_range(0, 65535));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept_val(rv);
            wait_done(1'b1, -1, '0, n, bn, v0);
            check($sformatf("rand_latency_%0d", i), 32'(n), 32'(WIDTH));
            check($sformatf("rand_bcd_%0d_%0d", i, rv), 32'(bcd_out), 32'(model(32'(rv))));
        end

        @(negedge clk);
        check("busy_valid_overlap", 32'(overlap), 32'd0);
        check("bcd_out_intermediate_change", 32'(bad_change), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
